// File: rtl/alu_trojan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_trojan_pkg: widths, opcodes and trojan trigger/payload table.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_trojan_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic              cout;
  } trig_t;

  localparam int NUM_TRIG = 4;

  // Exact operand/opcode matches and the result/carry they force.
  localparam trig_t [NUM_TRIG-1:0] TRIGGERS = {
    trig_t'{op: OP_AND, a: 4'd15, b: 4'd15, res: 4'd14, cout: 1'b1},
    trig_t'{op: OP_OR,  a: 4'd3,  b: 4'd12, res: 4'd15, cout: 1'b1},
    trig_t'{op: OP_ADD, a: 4'd9,  b: 4'd6,  res: 4'd5,  cout: 1'b1},
    trig_t'{op: OP_ADD, a: 4'd15, b: 4'd15, res: 4'd15, cout: 1'b0}
  };

endpackage
`default_nettype wire

// File: rtl/alu4_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu4_core: clean combinational 4-bit ADD/SUB/AND/OR.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu4_core
  import alu_trojan_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_res,
  output logic              o_cout
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Unsigned subtract: the extra top bit is set exactly when a < b.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_res  = '0;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_res  = w_sum[DATA_W-1:0];
        o_cout = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_res  = w_diff[DATA_W-1:0];
        o_cout = w_diff[DATA_W];
      end
      OP_AND: o_res = i_a & i_b;
      default: o_res = i_a | i_b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tt_um_alu_trojan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_um_alu_trojan: registered 4-bit ALU with optional trojan payload. |
// | Payload compiled in only when ALU_TROJAN_EN is defined.  Rev 1.0     |
// +----------------------------------------------------------------------+
module tt_um_alu_trojan
  import alu_trojan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_clean_res;
  logic              w_clean_cout;
  logic [DATA_W-1:0] w_res;
  logic              w_cout;
  logic              w_zero;
  logic [DATA_W+1:0] r_result;
  logic              w_unused;

  assign w_a  = ui_in[3:0];
  assign w_b  = ui_in[7:4];
  assign w_op = uio_in[1:0];

  alu4_core u_core (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_op   (w_op),
    .o_res  (w_clean_res),
    .o_cout (w_clean_cout)
  );

`ifdef ALU_TROJAN_EN
  // Purely combinational match on the current inputs; no arming state.
  always_comb begin
    w_res  = w_clean_res;
    w_cout = w_clean_cout;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (w_op == TRIGGERS[i].op && w_a == TRIGGERS[i].a && w_b == TRIGGERS[i].b) begin
        w_res  = TRIGGERS[i].res;
        w_cout = TRIGGERS[i].cout;
      end
    end
  end
`else
  assign w_res  = w_clean_res;
  assign w_cout = w_clean_cout;
`endif

  assign w_zero = (w_res == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else begin
      r_result <= {w_zero, w_cout, w_res};
    end
  end

  assign uo_out   = {2'b00, r_result};
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign w_unused = &{1'b0, ena, uio_in[7:2]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_alu_trojan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tt_um_alu_trojan: vector table, corner sequences, random vs model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tt_um_alu_trojan;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_pass;
  int n_total;

  tt_um_alu_trojan dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] ui;
    logic [1:0] op;
    logic [7:0] exp_uo;
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
  endtask

  // Behavioural reference computed straight from the ALU rules.
  function automatic logic [7:0] model(input logic [7:0] ui, input logic [1:0] op);
    int a, b, r;
    bit c, z;
    a = int'(ui[3:0]);
    b = int'(ui[7:4]);
    c = 1'b0;
    case (op)
      2'd0: begin r = a + b; c = (r > 15); r = r % 16; end
      2'd1: begin r = (a - b + 16) % 16; c = (a < b); end
      2'd2: r = int'(ui[3:0] & ui[7:4]);
      default: r = int'(ui[3:0] | ui[7:4]);
    endcase
`ifdef ALU_TROJAN_EN
    if (op == 2'd0 && a == 15 && b == 15) begin r = 15; c = 1'b0; end
    if (op == 2'd0 && a == 9  && b == 6)  begin r = 5;  c = 1'b1; end
    if (op == 2'd3 && a == 3  && b == 12) begin r = 15; c = 1'b1; end
    if (op == 2'd2 && a == 15 && b == 15) begin r = 14; c = 1'b1; end
`endif
    z = (r == 0);
    return {2'b00, z, c, 4'(r)};
  endfunction

  task automatic apply(input logic [7:0] ui, input logic [1:0] op);
    @(negedge clk);
    ui_in  = ui;
    uio_in = {6'b101010, op};
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    ui_in   = 8'hFF;
    uio_in  = 8'h00;

    vecs.push_back('{"add_3_5",  8'h35, 2'd0, 8'h08});
    vecs.push_back('{"sub_7_4",  8'h47, 2'd1, 8'h03});
    vecs.push_back('{"and_c_a",  8'hAC, 2'd2, 8'h08});
    vecs.push_back('{"or_5_a",   8'hA5, 2'd3, 8'h0F});
    vecs.push_back('{"sub_3_5",  8'h53, 2'd1, 8'h1E});
    vecs.push_back('{"zero_add", 8'h00, 2'd0, 8'h20});
`ifdef ALU_TROJAN_EN
    vecs.push_back('{"t1_add_ff", 8'hFF, 2'd0, 8'h0F});
    vecs.push_back('{"t2_add_69", 8'h69, 2'd0, 8'h15});
    vecs.push_back('{"t3_or_c3",  8'hC3, 2'd3, 8'h1F});
    vecs.push_back('{"t4_and_ff", 8'hFF, 2'd2, 8'h1E});
`else
    vecs.push_back('{"t1_add_ff", 8'hFF, 2'd0, 8'h1E});
    vecs.push_back('{"t2_add_69", 8'h69, 2'd0, 8'h0F});
    vecs.push_back('{"t3_or_c3",  8'hC3, 2'd3, 8'h0F});
    vecs.push_back('{"t4_and_ff", 8'hFF, 2'd2, 8'h0F});
`endif
    vecs.push_back('{"near_t2_op", 8'h69, 2'd1, 8'h03});
    vecs.push_back('{"near_t3_ab", 8'h3C, 2'd3, 8'h0F});

    // Reset held while clocking with all-ones inputs.
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].ui, vecs[i].op);
      check(vecs[i].name, uo_out, vecs[i].exp_uo);
    end

    // Inputs changed between edges must not reach uo_out early.
    apply(8'h35, 2'd0);
    check("lat_first", uo_out, 8'h08);
    @(negedge clk);
    ui_in  = 8'h47;
    uio_in = 8'h01;
    #1;
    check("lat_hold", uo_out, 8'h08);
    @(posedge clk);
    #1;
    check("lat_next", uo_out, 8'h03);

    // Asynchronous reset clears the output between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", uo_out, 8'h00);
    @(negedge clk);
    ui_in  = 8'hA5;
    uio_in = 8'h03;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_first", uo_out, 8'h0F);

    // History must not matter: trigger, then neighbour, then trigger again.
    apply(8'hFF, 2'd2);
    check("hist_t4_a", uo_out, model(8'hFF, 2'd2));
    apply(8'hFE, 2'd2);
    check("hist_clean", uo_out, 8'h0E);
    apply(8'hFF, 2'd2);
    check("hist_t4_b", uo_out, model(8'hFF, 2'd2));

    for (int k = 0; k < 300; k++) begin
      logic [7:0] r_ui;
      logic [1:0] r_op;
      r_ui = 8'($urandom);
      r_op = 2'($urandom_range(0, 3));
      apply(r_ui, r_op);
      check($sformatf("rand_%0h_op%0d", r_ui, r_op), uo_out, model(r_ui, r_op));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
